// File: rtl/seeg_seq_pkg.sv
// seeg_seq_pkg: shared types for the session sequencer (step entry layout, FSM states, error codes)
package seeg_seq_pkg;
  localparam logic [1:0] AXI_OKAY = 2'b00;
  typedef struct packed {
    logic        last;
    logic [21:0] wait_ticks;
    logic        target;
    logic [7:0]  offset;
    logic [31:0] wdata;
  } step_t;
  typedef enum logic [2:0] {
    IDLE, FETCH, WRITE, BRESP,
`ifdef SEQ_READBACK_EN
    READ,
`endif
    WAIT, DONE, ERROR
  } state_t;
  typedef enum logic [1:0] {ERR_NONE, ERR_BRESP, ERR_TIMEOUT, ERR_READBACK} err_code_t;
  function automatic logic [31:0] step_addr(step_t s, logic [31:0] rhd_base, logic [31:0] rhs_base);
    return (s.target ? rhs_base : rhd_base) + {24'b0, s.offset};
  endfunction
endpackage

// File: rtl/seeg_seq_tick.sv
// seeg_seq_tick: wait timer, TICK_DIV-cycle prescaler feeding a tick down-counter
//   clk, rst_n  clock / async active-low reset
//   load        restart the timer with ticks (prescaler phase cleared)
//   ticks       number of ticks to wait
//   expired     high in the final cycle of the wait (or whenever idle)
module seeg_seq_tick #(
  parameter int TICK_DIV = 100,
  parameter int TW = 22
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [TW-1:0] ticks,
  output logic          expired
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [PW-1:0] pre;
  logic [TW-1:0] cnt;
  logic wrap;
  assign wrap = pre == PW'(TICK_DIV - 1);
  assign expired = cnt == '0 || (cnt == TW'(1) && wrap);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pre <= '0;
      cnt <= '0;
    end else if (load) begin
      pre <= '0;
      cnt <= ticks;
    end else if (cnt != '0) begin
      pre <= wrap ? '0 : pre + 1'b1;
      if (wrap) cnt <= cnt - 1'b1;
    end
endmodule

// File: rtl/seeg_session_sequencer.sv
// seeg_session_sequencer: table-driven AXI4-Lite write sequencer for the RHD/RHS controllers
//   Host side : cfg_we/cfg_idx/cfg_entry load the step table while idle; start/abort pulses;
//               busy, sticky done/err, err_code, step report progress.
//   AXI side  : single-outstanding AXI4-Lite master (AW/W/B, plus AR/R for readback).
//   Define SEQ_READBACK_EN to read back and compare every written register.
module seeg_session_sequencer
  import seeg_seq_pkg::*;
#(
  parameter int          DEPTH        = 32,
  parameter logic [31:0] RHD_BASE     = 32'h4000_0000,
  parameter logic [31:0] RHS_BASE     = 32'h4001_0000,
  parameter int          TICK_DIV     = 100,
  parameter int          RESP_TIMEOUT = 1024
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     cfg_we,
  input  logic [$clog2(DEPTH)-1:0] cfg_idx,
  input  logic [63:0]              cfg_entry,
  input  logic                     start,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [1:0]               err_code,
  output logic [$clog2(DEPTH)-1:0] step,
  output logic [31:0]              m_axi_awaddr,
  output logic                     m_axi_awvalid,
  input  logic                     m_axi_awready,
  output logic [2:0]               m_axi_awprot,
  output logic [31:0]              m_axi_wdata,
  output logic [3:0]               m_axi_wstrb,
  output logic                     m_axi_wvalid,
  input  logic                     m_axi_wready,
  input  logic [1:0]               m_axi_bresp,
  input  logic                     m_axi_bvalid,
  output logic                     m_axi_bready,
  output logic [31:0]              m_axi_araddr,
  output logic                     m_axi_arvalid,
  input  logic                     m_axi_arready,
  output logic [2:0]               m_axi_arprot,
  input  logic [31:0]              m_axi_rdata,
  input  logic [1:0]               m_axi_rresp,
  input  logic                     m_axi_rvalid,
  output logic                     m_axi_rready
);
  localparam int SW = $clog2(DEPTH);
  localparam int TMW = $clog2(RESP_TIMEOUT) + 1;
  state_t state;
  err_code_t code;
  step_t tbl [DEPTH];
  step_t ent, cur;
  logic [TMW-1:0] tmo;
  logic abort_q, ab, ok, adv, tick_load, expired, last_eff, tmo_hit, aw_fin, w_fin;
  always_ff @(posedge aclk)
    if (cfg_we && !busy) tbl[cfg_idx] <= step_t'(cfg_entry);
  assign cur = tbl[step];
  assign ab = abort | abort_q;
  assign last_eff = ent.last || step == SW'(DEPTH - 1);
  assign tmo_hit = tmo == TMW'(RESP_TIMEOUT - 1);
  assign aw_fin = !m_axi_awvalid || m_axi_awready;
  assign w_fin = !m_axi_wvalid || m_axi_wready;
  assign err_code = code;
  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;
  assign m_axi_wstrb = 4'hF;
  assign m_axi_rready = 1'b1;
`ifdef SEQ_READBACK_EN
  assign ok = state == READ && m_axi_rvalid && m_axi_rresp == AXI_OKAY && m_axi_rdata == ent.wdata;
`else
  logic rd_unused;
  assign rd_unused = ^{m_axi_arready, m_axi_rvalid, m_axi_rresp, m_axi_rdata};
  assign m_axi_araddr = '0;
  assign m_axi_arvalid = 1'b0;
  assign ok = state == BRESP && m_axi_bvalid && m_axi_bresp == AXI_OKAY;
`endif
  // A completed step either finishes now (zero wait) or hands off to the tick timer
  assign tick_load = ok && !ab && ent.wait_ticks != '0;
  assign adv = (ok && !ab && ent.wait_ticks == '0) || (state == WAIT && !ab && expired);
  seeg_seq_tick #(.TICK_DIV(TICK_DIV), .TW(22)) u_tick (
    .clk(aclk),
    .rst_n(aresetn),
    .load(tick_load),
    .ticks(ent.wait_ticks),
    .expired(expired)
  );
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      state <= IDLE;
      step <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      code <= ERR_NONE;
      abort_q <= 1'b0;
      tmo <= '0;
      ent <= '0;
      m_axi_awaddr <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata <= '0;
      m_axi_wvalid <= 1'b0;
      m_axi_bready <= 1'b0;
`ifdef SEQ_READBACK_EN
      m_axi_araddr <= '0;
      m_axi_arvalid <= 1'b0;
`endif
    end else begin
      tmo <= tmo + 1'b1;
      if (busy && abort) abort_q <= 1'b1;
      case (state)
        IDLE, DONE, ERROR:
          if (start) begin
            state <= FETCH;
            step <= '0;
            busy <= 1'b1;
            done <= 1'b0;
            err <= 1'b0;
            code <= ERR_NONE;
            abort_q <= 1'b0;
          end else state <= IDLE;
        FETCH:
          if (ab) begin
            state <= IDLE;
            busy <= 1'b0;
          end else begin
            ent <= cur;
            m_axi_awaddr <= step_addr(cur, RHD_BASE, RHS_BASE);
            m_axi_wdata <= cur.wdata;
            m_axi_awvalid <= 1'b1;
            m_axi_wvalid <= 1'b1;
`ifdef SEQ_READBACK_EN
            m_axi_araddr <= step_addr(cur, RHD_BASE, RHS_BASE);
`endif
            tmo <= '0;
            state <= WRITE;
          end
        WRITE:
          if (aw_fin && w_fin) begin
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid <= 1'b0;
            m_axi_bready <= 1'b1;
            tmo <= '0;
            state <= BRESP;
          end else if (tmo_hit) begin
            // Valids are withdrawn without a handshake; the slave is considered dead
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid <= 1'b0;
            state <= ERROR;
            err <= 1'b1;
            busy <= 1'b0;
            code <= ERR_TIMEOUT;
          end else begin
            m_axi_awvalid <= m_axi_awvalid && !m_axi_awready;
            m_axi_wvalid <= m_axi_wvalid && !m_axi_wready;
          end
        BRESP:
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            if (m_axi_bresp != AXI_OKAY) begin
              state <= ERROR;
              err <= 1'b1;
              busy <= 1'b0;
              code <= ERR_BRESP;
            end
`ifdef SEQ_READBACK_EN
            else begin
              m_axi_arvalid <= 1'b1;
              tmo <= '0;
              state <= READ;
            end
`endif
          end else if (tmo_hit) begin
            m_axi_bready <= 1'b0;
            state <= ERROR;
            err <= 1'b1;
            busy <= 1'b0;
            code <= ERR_TIMEOUT;
          end
`ifdef SEQ_READBACK_EN
        READ:
          if (m_axi_rvalid) begin
            m_axi_arvalid <= 1'b0;
            if (m_axi_rresp != AXI_OKAY || m_axi_rdata != ent.wdata) begin
              state <= ERROR;
              err <= 1'b1;
              busy <= 1'b0;
              code <= m_axi_rresp != AXI_OKAY ? ERR_BRESP : ERR_READBACK;
            end
          end else if (tmo_hit) begin
            m_axi_arvalid <= 1'b0;
            state <= ERROR;
            err <= 1'b1;
            busy <= 1'b0;
            code <= ERR_TIMEOUT;
          end else m_axi_arvalid <= m_axi_arvalid && !m_axi_arready;
`endif
        WAIT:
          if (ab) begin
            state <= IDLE;
            busy <= 1'b0;
          end
        default: state <= IDLE;
      endcase
      // Successful step completion: an abort pending since mid-handshake lands here
      if (ok) begin
        if (ab) begin
          state <= IDLE;
          busy <= 1'b0;
        end else if (ent.wait_ticks != '0) state <= WAIT;
      end
      if (adv) begin
        if (last_eff) begin
          state <= DONE;
          done <= 1'b1;
          busy <= 1'b0;
        end else begin
          step <= step + 1'b1;
          state <= FETCH;
        end
      end
    end
endmodule

// File: doc/seeg_session_sequencer.md
Name: seeg_session_sequencer

Overview:
Table-driven AXI4-Lite master that replays a programmed register-write sequence into the RHD acquisition and RHS stimulation controllers. A host loads the sequence into an internal step table, pulses start, and the block issues writes with per-step timed waits. Typical sequence: delays, packet lengths, stim magnitude/channel/timing, init pulse, magnitude set, stim enable, acquisition start. Sits on the control fabric; the AXI interconnect downstream handles CDC into rhd_aclk/rhs_aclk.

Parameters:
DEPTH, 32, step-table entries (power of 2)
RHD_BASE, 32'h4000_0000, RHD register block base address
RHS_BASE, 32'h4001_0000, RHS register block base address
TICK_DIV, 100, aclk cycles per wait tick (1 us at 100 MHz)
RESP_TIMEOUT, 1024, aclk cycles allowed per AXI handshake before error

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
cfg_we  in  1  table write strobe
cfg_idx  in  $clog2(DEPTH)  table index
cfg_entry  in  64  step entry: [31:0] wdata, [39:32] byte offset, [40] target (0 RHD, 1 RHS), [62:41] wait ticks, [63] last
start  in  1  pulse: run from step 0
abort  in  1  pulse: stop after current handshake
busy  out  1  sequence running
done  out  1  sticky: completed at last step, cleared by start
err  out  1  sticky: error, cleared by start
err_code  out  2  0 none, 1 bad BRESP, 2 timeout, 3 readback mismatch
step  out  $clog2(DEPTH)  current/last step index
m_axi_awaddr/awvalid/awready/awprot  out/out/in/out  32/1/1/3  write address (awprot = 3'b000)
m_axi_wdata/wstrb/wvalid/wready  out/out/out/in  32/4/1/1  write data (wstrb = 4'hF)
m_axi_bresp/bvalid/bready  in/in/out  2/1/1  write response
m_axi_araddr/arvalid/arready/arprot  out/out/in/out  32/1/1/3  read address
m_axi_rdata/rresp/rvalid/rready  in/in/in/out  32/2/1/1  read data

Behaviour:
- Reset: all outputs 0, state IDLE, table contents undefined (not cleared).
- cfg_we honoured only when busy=0; ignored while busy.
- States: IDLE, FETCH, WRITE, BRESP, READ (feature only), WAIT, DONE, ERROR.
- IDLE: start -> step=0, done=err=0, err_code=0, busy=1, FETCH.
- FETCH: one cycle table read; address = (target ? RHS_BASE : RHD_BASE) + {24'b0, offset}. -> WRITE.
- WRITE: awvalid and wvalid asserted in the same cycle, each dropped independently on its own ready; never deasserted before handshake. When both complete -> BRESP with bready=1.
- BRESP: bvalid & bresp==OKAY -> READ (feature) or WAIT; bresp!=OKAY -> ERROR code 1.
- Timeout counter resets on entry to WRITE/BRESP/READ; reaching RESP_TIMEOUT -> ERROR code 2. Valids are dropped on timeout (deliberate protocol break; logged).
- WAIT: wait ticks==0 -> zero extra cycles. Otherwise prescaler counts TICK_DIV cycles per tick, exits after exactly ticks*TICK_DIV cycles. Then last -> DONE, else step+1 -> FETCH.
- Step wrap: step DEPTH-1 without last is treated as last.
- DONE: done=1, busy=0 -> IDLE next cycle. ERROR: err=1, busy=0 -> IDLE.
- abort: latched. In WAIT/FETCH -> IDLE immediately. In WRITE/BRESP/READ -> completes the outstanding handshake, then IDLE. done stays 0. step holds the aborted index.
- start while busy: ignored. start and abort in the same cycle in IDLE: start wins.
- Minimum per-step latency with zero wait and zero-latency slave: FETCH 1 + WRITE 1 + BRESP 1 = 3 cycles.

Optional Feature:
SEQ_READBACK_EN: when defined, READ issues an AR to the same address after each write, with rready=1. Then rresp!=OKAY -> ERROR code 1, rdata!=wdata -> ERROR code 3, else WAIT. When undefined, arvalid=0, rready=1, araddr=0, and the READ state is absent.

Decomposition:
- Package seeg_seq_pkg: step_t packed struct (wdata, offset, target, wait, last), state enum, err_code enum, AXI_OKAY constant.
- Sub-module seeg_seq_tick: prescaler plus wait-tick down-counter with load/start/expired.

Test Plan:
- Load 2 steps (RHS off 0x04 0x80FF80FF wait 0; RHD off 0x08 0x2 wait 0 last), start -> writes to 0x4001_0004 then 0x4000_0008, done=1, err=0, step=1.
- Step RHS off 0x00 data 0x23 wait 500, TICK_DIV=100 -> next AW exactly 50000 cycles after BRESP handshake.
- Slave returns SLVERR on step 2 of 4 -> err=1, err_code=1, step=2, no further AW.
- Slave holds awready=0 -> err_code=2 after 1024 cycles, busy=0.
- abort during WAIT of step 3 -> busy=0 next cycle, done=0, step=3; restart replays from step 0.
- SEQ_READBACK_EN: slave returns rdata 0x80FF80FE for written 0x80FF80FF -> err_code=3. Without the macro, arvalid never asserts.
